// File: rtl/alu_ctrl.sv
// alu_ctrl: shares one combinational 32-bit ALU between two requesters.
//
// One operation is in flight at a time. Requesters are chosen round-robin in
// IDLE. The accepted operands/opcode are driven to the ALU and held for an
// op-dependent number of EXEC cycles, then the result is returned with the
// requester id and an error flag over a valid/ready response channel.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   reqN_valid/_ready           request handshake for requester N (0/1)
//   reqN_a/_b/_op               request operands and opcode
//   alu_a/_b/_op                operands and opcode to the ALU
//   alu_out                     combinational ALU result
//   rsp_valid/_ready            response handshake
//   rsp_id/_data/_err           requester id, result, error flag
module alu_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MAX = 4'd9;   // codes above this are illegal

    localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    // Arbitration: a lone valid wins; on a tie the one not granted last wins.
    logic        sel;
    logic        any_valid;
    logic [31:0] acc_a, acc_b;
    logic [3:0]  acc_op;

    always_comb begin
        any_valid = req0_valid | req1_valid;
        sel       = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        acc_a     = sel ? req1_a  : req0_a;
        acc_b     = sel ? req1_b  : req0_b;
        acc_op    = sel ? req1_op : req0_op;
        req0_ready = (state_q == S_IDLE) & req0_valid & ~sel;
        req1_ready = (state_q == S_IDLE) & req1_valid &  sel;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    alu_a_d      = acc_a;
                    alu_b_d      = acc_b;
                    alu_op_d     = acc_op;
                    rsp_id_d     = sel;
                    last_grant_d = sel;
                    // Errors are known at accept time, so skip EXEC entirely.
                    if (acc_op > OP_MAX) begin
                        rsp_data_d = 32'h0;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end else if (acc_op == OP_DIV && acc_b == 32'h0) begin
                        rsp_data_d = 32'hFFFF_FFFF;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        if (acc_op == OP_MUL)      cnt_d = MUL_N;
                        else if (acc_op == OP_DIV) cnt_d = DIV_N;
                        else                       cnt_d = 4'd1;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - 4'd1;
                // <= 1 rather than == 1 so a zero count can never wedge EXEC.
                if (cnt_q <= 4'd1) begin
                    rsp_data_d = alu_out;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;      // requester 0 wins the first tie
            cnt_q        <= 4'd0;
            alu_a_q      <= 32'h0;
            alu_b_q      <= 32'h0;
            alu_op_q     <= 4'h0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= 32'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: self-checking bench for alu_ctrl. The ALU is modelled here;
// expected results, latencies and grants come from the opcode table and the
// round-robin rule applied directly to the request fields.
module tb_alu_ctrl;
    localparam int MULN = 4;
    localparam int DIVN = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;

    int checks = 0;
    int errors = 0;
    logic m_last;   // requester granted most recently (model)

    always #5 clk = ~clk;

    alu_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * b;
            4'd3: return (b == 0) ? 32'hDEAD_BEEF : a / b;
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd7: return ~a;
            4'd8: return a << b[4:0];
            4'd9: return a >> b[4:0];
            default: return 32'h0BAD_0BAD;
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_op, alu_a, alu_b);

    // {err, data} expected for a request
    function automatic logic [32:0] ref_rsp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op > 4'd9) return {1'b1, 32'h0};
        if (op == 4'd3 && b == 0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, alu_fn(op, a, b)};
    endfunction

    // cycles from accept edge to rsp_valid
    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        if (op > 4'd9 || (op == 4'd3 && b == 0)) return 1;
        if (op == 4'd2) return 1 + MULN;
        if (op == 4'd3) return 1 + DIVN;
        return 2;
    endfunction

    task automatic drive(input logic v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    endtask

    // Called right after the accept edge; returns at the negedge rsp_valid is seen
    // (or after a bounded wait). Records whether alu_* drifted or any ready rose.
    task automatic wait_rsp(input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] eop,
                            output int lat, output bit alu_ok, output bit rdy_ok);
        lat = 0; alu_ok = 1; rdy_ok = 1;
        do begin
            @(negedge clk);
            lat++;
            if (req0_ready || req1_ready) rdy_ok = 0;
            if (!rsp_valid && {alu_a, alu_b, alu_op} !== {ea, eb, eop}) alu_ok = 0;
        end while (!rsp_valid && lat < 40);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; rsp_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1; m_last = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== 35'h0) begin errors++; $display("FAIL reset_rsp: got v%b id%b e%b d%h exp all 0", rsp_valid, rsp_id, rsp_err, rsp_data); end
        checks++; if ({alu_a, alu_b, alu_op} !== 68'h0) begin errors++; $display("FAIL reset_alu: got %h %h %h exp 0", alu_a, alu_b, alu_op); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b%b exp 00", req0_ready, req1_ready); end
    endtask

    task automatic test_add();
        int lat; bit aok, rok;
        @(negedge clk);
        drive(1, 4'd0, 32'd5, 32'd7, 0, 0, 0, 0); #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL add_ready: got %b%b exp 10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        m_last = 0; drive(0, 4'hF, 32'hFFFF, 32'hAAAA, 0, 0, 0, 0);
        wait_rsp(32'd5, 32'd7, 4'd0, lat, aok, rok);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_lat: got %0d exp 2", lat); end
        checks++; if ({rsp_err, rsp_id, rsp_data} !== {1'b0, 1'b0, 32'd12}) begin errors++; $display("FAIL add_rsp: got e%b id%b d%h exp e0 id0 d0000000c", rsp_err, rsp_id, rsp_data); end
        take_rsp();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_drop: rsp_valid got %b exp 0", rsp_valid); end
    endtask

    task automatic test_contention();
        logic [3:0] po[2]; logic [31:0] pa[2], pb[2];
        logic g; logic [32:0] er; int el, lat; bit aok, rok;
        do_reset();
        po[0] = 4'd1; pa[0] = 32'd10;   pb[0] = 32'd3;
        po[1] = 4'd6; pa[1] = 32'hF0;   pb[1] = 32'h0F;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, po[0], pa[0], pb[0], 1, po[1], pa[1], pb[1]); #1;
            g = ~m_last;
            checks++; if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_grant%0d: got r1r0=%b%b exp grant %0d", k, req1_ready, req0_ready, g); end
            er = ref_rsp(po[g], pa[g], pb[g]); el = ref_lat(po[g], pb[g]);
            @(posedge clk); #1;
            m_last = g;
            begin
                logic [3:0] ea_op; logic [31:0] ea, eb;
                ea_op = po[g]; ea = pa[g]; eb = pb[g];
                po[g] = 4'($urandom_range(4, 6)); pa[g] = $urandom; pb[g] = $urandom;
                drive(1, po[0], pa[0], pb[0], 1, po[1], pa[1], pb[1]);
                wait_rsp(ea, eb, ea_op, lat, aok, rok);
            end
            checks++; if (lat !== el || !aok || !rok) begin errors++; $display("FAIL cont_timing%0d: lat %0d exp %0d alu_held %0d ready_low %0d", k, lat, el, aok, rok); end
            checks++; if ({rsp_err, rsp_id, rsp_data} !== {er[32], g, er[31:0]}) begin errors++; $display("FAIL cont_rsp%0d: got e%b id%b d%h exp e%b id%b d%h", k, rsp_err, rsp_id, rsp_data, er[32], g, er[31:0]); end
            take_rsp();
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_mul();
        int lat; bit aok, rok;
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 4'd2, 32'd6, 32'd7); #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL mul_ready: got %b%b exp 01", req0_ready, req1_ready); end
        @(posedge clk); #1;
        m_last = 1; drive(0, 0, 0, 0, 0, 4'd0, 32'd1, 32'd1);
        wait_rsp(32'd6, 32'd7, 4'd2, lat, aok, rok);
        checks++; if (lat !== 1 + MULN || !aok) begin errors++; $display("FAIL mul_timing: lat %0d exp %0d alu_held %0d", lat, 1 + MULN, aok); end
        checks++; if ({rsp_err, rsp_id, rsp_data} !== {1'b0, 1'b1, 32'd42}) begin errors++; $display("FAIL mul_rsp: got e%b id%b d%h exp e0 id1 d0000002a", rsp_err, rsp_id, rsp_data); end
        take_rsp();
    endtask

    task automatic test_errors();
        int lat; bit aok, rok;
        logic [3:0] ops[2]; logic [31:0] bs[2], ed[2];
        ops[0] = 4'd3; bs[0] = 32'd0; ed[0] = 32'hFFFF_FFFF;
        ops[1] = 4'hC; bs[1] = 32'd4; ed[1] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1, ops[k], 32'd9, bs[k], 0, 0, 0, 0);
            @(posedge clk); #1;
            m_last = 0; drive(0, 0, 0, 0, 0, 0, 0, 0);
            wait_rsp(32'd9, bs[k], ops[k], lat, aok, rok);
            checks++; if (lat !== 1) begin errors++; $display("FAIL err_lat%0d: got %0d exp 1", k, lat); end
            checks++; if ({rsp_err, rsp_id, rsp_data} !== {1'b1, 1'b0, ed[k]}) begin errors++; $display("FAIL err_rsp%0d: got e%b id%b d%h exp e1 id0 d%h", k, rsp_err, rsp_id, rsp_data, ed[k]); end
            take_rsp();
        end
    endtask

    task automatic test_backpressure();
        int lat; bit aok, rok, ok; logic [31:0] d0;
        @(negedge clk);
        drive(1, 4'd0, 32'd100, 32'd23, 0, 0, 0, 0);
        @(posedge clk); #1;
        m_last = 0; drive(0, 0, 0, 0, 0, 0, 0, 0);
        wait_rsp(32'd100, 32'd23, 4'd0, lat, aok, rok);
        d0 = rsp_data;
        checks++; if (d0 !== 32'd123) begin errors++; $display("FAIL bp_data: got %h exp 0000007b", d0); end
        drive(1, 4'd4, 32'hFF00, 32'h0FF0, 0, 0, 0, 0);
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!rsp_valid || rsp_data !== d0 || req0_ready || req1_ready) ok = 0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL bp_hold: held %0d exp 1", ok); end
        take_rsp();
        @(negedge clk); #1;
        checks++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin errors++; $display("FAIL bp_accept: got v%b r0%b r1%b exp v0 r01 r10", rsp_valid, req0_ready, req1_ready); end
        @(posedge clk); #1;
        m_last = 0; drive(0, 0, 0, 0, 0, 0, 0, 0);
        wait_rsp(32'hFF00, 32'h0FF0, 4'd4, lat, aok, rok);
        checks++; if (lat !== 2 || rsp_data !== 32'h0F00) begin errors++; $display("FAIL bp_rsp: lat %0d d%h exp lat 2 d00000f00", lat, rsp_data); end
        take_rsp();
    endtask

    task automatic test_reset_mid_exec();
        int lat; bit aok, rok, seen;
        @(negedge clk);
        drive(1, 4'd3, 32'd100, 32'd5, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; m_last = 1;
        @(negedge clk);
        checks++; if ({rsp_valid, alu_a, alu_op} !== 37'h0) begin errors++; $display("FAIL rst_exec_clear: got v%b a%h op%h exp 0", rsp_valid, alu_a, alu_op); end
        seen = 0;
        repeat (15) begin @(negedge clk); if (rsp_valid) seen = 1; end
        checks++; if (seen) begin errors++; $display("FAIL rst_exec_norsp: rsp_valid seen %0d exp 0", seen); end
        drive(1, 4'd8, 32'd3, 32'd4, 1, 4'd0, 32'd20, 32'd22); #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rst_exec_grant: got %b%b exp 10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        m_last = 0; drive(0, 0, 0, 0, 0, 0, 0, 0);
        wait_rsp(32'd3, 32'd4, 4'd8, lat, aok, rok);
        checks++; if (lat !== 2 || {rsp_err, rsp_id, rsp_data} !== {1'b0, 1'b0, 32'd48}) begin errors++; $display("FAIL rst_exec_fresh: lat %0d e%b id%b d%h exp lat 2 e0 id0 d00000030", lat, rsp_err, rsp_id, rsp_data); end
        take_rsp();
    endtask

    task automatic test_random();
        int v, lat, el; bit aok, rok; logic g; logic [32:0] er;
        logic [3:0] o[2]; logic [31:0] a[2], b[2], d0;
        for (int k = 0; k < 40; k++) begin
            v = $urandom_range(1, 3);
            for (int r = 0; r < 2; r++) begin
                o[r] = 4'($urandom_range(0, 15)); a[r] = $urandom;
                b[r] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            end
            @(negedge clk);
            drive(v[0], o[0], a[0], b[0], v[1], o[1], a[1], b[1]); #1;
            g = (v == 3) ? ~m_last : (v == 2);
            checks++; if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_grant%0d: got r1r0=%b%b exp grant %0d", k, req1_ready, req0_ready, g); end
            er = ref_rsp(o[g], a[g], b[g]); el = ref_lat(o[g], b[g]);
            @(posedge clk); #1;
            m_last = g; drive(0, 0, 0, 0, 0, 0, 0, 0);
            wait_rsp(a[g], b[g], o[g], lat, aok, rok);
            checks++; if (lat !== el || !aok || !rok) begin errors++; $display("FAIL rnd_timing%0d: lat %0d exp %0d alu_held %0d ready_low %0d", k, lat, el, aok, rok); end
            checks++; if ({rsp_err, rsp_id, rsp_data} !== {er[32], g, er[31:0]}) begin errors++; $display("FAIL rnd_rsp%0d: op %h got e%b id%b d%h exp e%b id%b d%h", k, o[g], rsp_err, rsp_id, rsp_data, er[32], g, er[31:0]); end
            d0 = rsp_data;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++; if (!rsp_valid || rsp_data !== d0) begin errors++; $display("FAIL rnd_hold%0d: v%b d%h exp v1 d%h", k, rsp_valid, rsp_data, d0); end
            take_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_contention();
        test_mul();
        test_errors();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
- Sequencer and arbiter that shares the single 32-bit ALU between two requesters, e.g. the instruction path (port 0) and the debug/test path (port 1).
- Accepts one operation at a time over a valid/ready handshake and picks between requesters round-robin.
- Drives the ALU operands and opcode, holding them stable for an op-dependent number of cycles.
- Captures the ALU result and returns it with the requester ID and an error flag over a second valid/ready handshake.

Parameters:
- MUL_CYCLES, 4, number of EXEC cycles for OP_MUL (allowed range 1..15).
- DIV_CYCLES, 8, number of EXEC cycles for OP_DIV (allowed range 1..15).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  controller accepts requester 0 this cycle.
- req0_a  input  32  requester 0 operand a.
- req0_b  input  32  requester 0 operand b.
- req0_op  input  4  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as above, for requester 1.
- alu_a  output  32  operand a to the ALU.
- alu_b  output  32  operand b to the ALU.
- alu_op  output  4  opcode to the ALU.
- alu_out  input  32  combinational ALU result.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester that issued the operation.
- rsp_data  output  32  result.
- rsp_err  output  1  illegal opcode, or division by zero.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 SHL, 9 SHR. Codes 10..15 are illegal.
- States: IDLE, EXEC, RESP.
- Reset (reset==0 at a clk edge):
  - state = IDLE; all outputs 0; cycle counter 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
  - Reset wins over every other event in any state; an in-flight operation is dropped with no response.
- IDLE:
  - reqN_ready goes high combinationally only for the selected requester, and only in IDLE.
  - If only one valid is high, that requester is selected.
  - If both are high, the requester != last_grant is selected.
  - On acceptance (valid & ready):
    - latch a, b, op and id into alu_a/alu_b/alu_op/rsp_id, and set last_grant = id;
    - load the counter with 1 for single-cycle ops, MUL_CYCLES for MUL, DIV_CYCLES for DIV;
    - go to EXEC.
  - Illegal opcode: go directly to RESP with rsp_data=0 and rsp_err=1; the counter is not used.
  - DIV with b==0: go directly to RESP with rsp_data=32'hFFFF_FFFF and rsp_err=1.
- EXEC:
  - alu_a, alu_b and alu_op are held stable; the counter decrements each cycle.
  - In the cycle the counter equals 1: capture alu_out into rsp_data, set rsp_err=0, go to RESP.
  - Latency from the accept edge to rsp_valid high is 1 + N cycles, where N is the loaded count (ADD: rsp_valid is high 2 cycles after acceptance).
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable until rsp_ready is sampled high.
  - On the rsp_ready handshake: rsp_valid drops next cycle and the state returns to IDLE.
  - A new request can be accepted no earlier than the cycle after the handshake, so there is no overlap and at most one operation is in flight.
- Handshake rules:
  - Request fields are sampled only at acceptance and may change freely afterwards.
  - A requester that is not granted keeps its valid high; the controller never drops it.
  - reqN_ready is 0 in EXEC and RESP.
- Fairness: under continuous contention, grants alternate 0,1,0,1,...
- alu_a, alu_b and alu_op keep their last values outside EXEC; they are not cleared.

Test Plan:
1. Reset, then req0 issues ADD a=5, b=7 -> req0_ready high in cycle 0; rsp_valid 2 cycles later with rsp_data=12, rsp_id=0, rsp_err=0.
2. req0 and req1 both valid and held, SUB 10-3 and XOR F0^0F -> grants go 0 then 1; responses 7 (id 0) then FF (id 1); a third contended request goes to 0.
3. req1 issues MUL 6*7 with MUL_CYCLES=4 -> alu_* stable for 4 cycles; rsp_valid at accept+5 with data=42.
4. req0 issues DIV 9/0 -> rsp_valid at accept+1, rsp_data=FFFFFFFF, rsp_err=1. Then opcode 4'hC -> rsp_data=0, rsp_err=1.
5. rsp_ready held low for 10 cycles after a response -> rsp_valid and rsp_data stable throughout, req*_ready stay 0 while req0 is pending, and req0 is accepted the cycle after rsp_ready rises.
6. reset asserted for 1 cycle mid-EXEC of a DIV -> next cycle state is IDLE, rsp_valid=0, no response ever appears, and a fresh request is accepted normally.
